// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: channel state encoding and
// latency counter sizing.
package mem_responder_pkg;

    typedef logic [2:0] chan_state_t;

    localparam chan_state_t ST_IDLE          = 3'd0;
    localparam chan_state_t ST_READ_WAIT     = 3'd1;
    localparam chan_state_t ST_WRITE_WAIT    = 3'd2;
    localparam chan_state_t ST_RESPOND_READ  = 3'd3;
    localparam chan_state_t ST_RESPOND_WRITE = 3'd4;

    // One extra bit keeps the counter wide enough for LATENCY-1 in every case.
    function automatic int unsigned lat_cnt_bits(input int unsigned rd_lat,
                                                 input int unsigned wr_lat);
        int unsigned longest;
        longest = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/mem_responder_channel.sv
// One request channel: accepts a single read or write, waits out the fixed
// latency, emits commit strobes toward storage and a one-cycle ready pulse.
module mem_responder_channel
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 2,
    parameter int unsigned WRITE_ENABLE  = 1
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid,
    input  logic [ADDR_BITS-1:0] read_address,
    input  logic                 write_valid,
    input  logic [ADDR_BITS-1:0] write_address,
    input  logic [DATA_BITS-1:0] write_data,
    output logic                 read_ready,
    output logic                 write_ready,
    output logic                 read_commit,
    output logic                 write_commit,
    output logic [ADDR_BITS-1:0] commit_address,
    output logic [DATA_BITS-1:0] commit_data
);

    localparam int unsigned CNT_BITS = lat_cnt_bits(READ_LATENCY, WRITE_LATENCY);
    localparam logic [CNT_BITS-1:0] RD_LOAD = CNT_BITS'(READ_LATENCY - 1);
    localparam logic [CNT_BITS-1:0] WR_LOAD = CNT_BITS'(WRITE_LATENCY - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    chan_state_t          state;
    logic [CNT_BITS-1:0]  count;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 accept_read;
    logic                 accept_write;
    logic                 wait_done;

    // Read wins over a simultaneous write; the write stays pending at the initiator.
    assign accept_read  = (state == ST_IDLE) && read_valid;
    assign accept_write = (WRITE_ENABLE != 0) && (state == ST_IDLE) && !read_valid && write_valid;
    assign wait_done    = (count == CNT_ONE);

    // Strobes mark the edge that enters RESPOND_*; a latency of 1 commits on the accept edge.
    assign read_commit  = !reset && ((accept_read && (READ_LATENCY == 1)) ||
                                     ((state == ST_READ_WAIT) && wait_done));
    assign write_commit = !reset && ((accept_write && (WRITE_LATENCY == 1)) ||
                                     ((state == ST_WRITE_WAIT) && wait_done));

    assign commit_address = (state == ST_IDLE) ? (read_valid ? read_address : write_address) : addr_q;
    assign commit_data    = (state == ST_IDLE) ? write_data : data_q;

    assign read_ready  = (state == ST_RESPOND_READ);
    assign write_ready = (WRITE_ENABLE != 0) && (state == ST_RESPOND_WRITE);

    always_ff @(posedge clk) begin
        if (accept_read) begin
            addr_q <= read_address;
        end else if (accept_write) begin
            addr_q <= write_address;
            data_q <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_read) begin
                        count <= RD_LOAD;
                        state <= (READ_LATENCY == 1) ? ST_RESPOND_READ : ST_READ_WAIT;
                    end else if (accept_write) begin
                        count <= WR_LOAD;
                        state <= (WRITE_LATENCY == 1) ? ST_RESPOND_WRITE : ST_WRITE_WAIT;
                    end
                end
                ST_READ_WAIT: begin
                    count <= count - CNT_ONE;
                    if (wait_done) state <= ST_RESPOND_READ;
                end
                ST_WRITE_WAIT: begin
                    count <= count - CNT_ONE;
                    if (wait_done) state <= ST_RESPOND_WRITE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: NUM_CHANNELS independent request channels over one
// shared storage array, plus a backdoor load port for preload.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CHANNELS  = 1,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 2,
    parameter int unsigned WRITE_ENABLE  = 1
)(
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    output logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_ready,
    input  logic                                    load_enable,
    input  logic [ADDR_BITS-1:0]                    load_address,
    input  logic [DATA_BITS-1:0]                    load_data
);

    logic [DATA_BITS-1:0] storage [2**ADDR_BITS];

    logic [NUM_CHANNELS-1:0]                read_commit;
    logic [NUM_CHANNELS-1:0]                write_commit;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] commit_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] commit_data;

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        mem_responder_channel #(
            .ADDR_BITS     (ADDR_BITS),
            .DATA_BITS     (DATA_BITS),
            .READ_LATENCY  (READ_LATENCY),
            .WRITE_LATENCY (WRITE_LATENCY),
            .WRITE_ENABLE  (WRITE_ENABLE)
        ) u_channel (
            .clk            (clk),
            .reset          (reset),
            .read_valid     (mem_read_valid[ch]),
            .read_address   (mem_read_address[ch]),
            .write_valid    (mem_write_valid[ch]),
            .write_address  (mem_write_address[ch]),
            .write_data     (mem_write_data[ch]),
            .read_ready     (mem_read_ready[ch]),
            .write_ready    (mem_write_ready[ch]),
            .read_commit    (read_commit[ch]),
            .write_commit   (write_commit[ch]),
            .commit_address (commit_address[ch]),
            .commit_data    (commit_data[ch])
        );
    end

    // Later assignments win: higher channel over lower, load port over all.
    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (write_commit[ch]) storage[commit_address[ch]] <= commit_data[ch];
        end
        if (load_enable) storage[load_address] <= load_data;
    end

    // Read data lives only for the ready cycle; same-edge writes are not yet visible.
    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (reset || !read_commit[ch]) mem_read_data[ch] <= '0;
            else                           mem_read_data[ch] <= storage[commit_address[ch]];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a two-channel read/write instance and
// a single-channel read-only instance with a longer read latency.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: 2 channels, latency 2/2, writable.
    logic            a_reset;
    logic [1:0]      a_rv, a_rr, a_wv, a_wr;
    logic [1:0][7:0] a_ra, a_rd, a_wa, a_wd;
    logic            a_le;
    logic [7:0]      a_la, a_ld;

    // Instance B: 1 channel, read latency 4, read-only.
    logic       b_reset;
    logic       b_rv, b_rr, b_wv, b_wr, b_le;
    logic [7:0] b_ra, b_rd, b_wa, b_wd, b_la, b_ld;

    logic [7:0] model_a [256];

    mem_responder #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(2),
        .READ_LATENCY(2), .WRITE_LATENCY(2), .WRITE_ENABLE(1)
    ) dut_a (
        .clk(clk), .reset(a_reset),
        .mem_read_valid(a_rv), .mem_read_address(a_ra),
        .mem_read_ready(a_rr), .mem_read_data(a_rd),
        .mem_write_valid(a_wv), .mem_write_address(a_wa),
        .mem_write_data(a_wd), .mem_write_ready(a_wr),
        .load_enable(a_le), .load_address(a_la), .load_data(a_ld)
    );

    mem_responder #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(1),
        .READ_LATENCY(4), .WRITE_LATENCY(1), .WRITE_ENABLE(0)
    ) dut_b (
        .clk(clk), .reset(b_reset),
        .mem_read_valid(b_rv), .mem_read_address(b_ra),
        .mem_read_ready(b_rr), .mem_read_data(b_rd),
        .mem_write_valid(b_wv), .mem_write_address(b_wa),
        .mem_write_data(b_wd), .mem_write_ready(b_wr),
        .load_enable(b_le), .load_address(b_la), .load_data(b_ld)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_a(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        a_le = 1'b1; a_la = addr; a_ld = data;
        @(negedge clk);
        a_le = 1'b0;
        model_a[addr] = data;
    endtask

    task automatic load_b(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        b_le = 1'b1; b_la = addr; b_ld = data;
        @(negedge clk);
        b_le = 1'b0;
    endtask

    // Drives one read on A; reports latency in cycles, data, data after ready, extra pulses.
    task automatic read_a(input int ch, input logic [7:0] addr, output int lat,
                          output logic [7:0] data, output logic [7:0] post, output int extra);
        @(negedge clk);
        a_rv[ch] = 1'b1; a_ra[ch] = addr;
        lat = 0; data = '0;
        while (lat < 50) begin
            @(negedge clk); lat++;
            if (a_rr[ch]) break;
        end
        data = a_rd[ch];
        @(negedge clk);
        a_rv[ch] = 1'b0;
        post  = a_rd[ch];
        extra = a_rr[ch] ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (a_rr[ch]) extra++;
        end
    endtask

    task automatic write_a(input int ch, input logic [7:0] addr, input logic [7:0] data,
                           output int lat, output int extra);
        @(negedge clk);
        a_wv[ch] = 1'b1; a_wa[ch] = addr; a_wd[ch] = data;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk); lat++;
            if (a_wr[ch]) break;
        end
        @(negedge clk);
        a_wv[ch] = 1'b0;
        extra = a_wr[ch] ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (a_wr[ch]) extra++;
        end
    endtask

    task automatic read_b(input logic [7:0] addr, output int lat, output logic [7:0] data);
        @(negedge clk);
        b_rv = 1'b1; b_ra = addr;
        lat = 0; data = '0;
        while (lat < 50) begin
            @(negedge clk); lat++;
            if (b_rr) break;
        end
        data = b_rd;
        @(negedge clk);
        b_rv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (a_rr !== 2'b00) begin failures++; $display("FAIL reset_a_read_ready got=%b want=00", a_rr); end
        checks++; if (a_wr !== 2'b00) begin failures++; $display("FAIL reset_a_write_ready got=%b want=00", a_wr); end
        checks++; if (a_rd !== 16'h0000) begin failures++; $display("FAIL reset_a_read_data got=%h want=0000", a_rd); end
        checks++; if (b_rr !== 1'b0) begin failures++; $display("FAIL reset_b_read_ready got=%b want=0", b_rr); end
        checks++; if (b_wr !== 1'b0) begin failures++; $display("FAIL reset_b_write_ready got=%b want=0", b_wr); end
        checks++; if (b_rd !== 8'h00) begin failures++; $display("FAIL reset_b_read_data got=%h want=00", b_rd); end
        a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_latency();
        int lat, extra;
        logic [7:0] data, post;
        load_a(8'h05, 8'h3C);
        read_a(0, 8'h05, lat, data, post, extra);
        checks++; if (lat !== 2) begin failures++; $display("FAIL read_latency got=%0d want=2", lat); end
        checks++; if (data !== 8'h3C) begin failures++; $display("FAIL read_data got=%h want=3c", data); end
        checks++; if (post !== 8'h00) begin failures++; $display("FAIL read_data_after_ready got=%h want=00", post); end
        checks++; if (extra !== 0) begin failures++; $display("FAIL read_single_pulse extra=%0d want=0", extra); end
    endtask

    task automatic test_write_read();
        int lat, extra;
        logic [7:0] data, post;
        write_a(0, 8'h10, 8'hA7, lat, extra);
        model_a[8'h10] = 8'hA7;
        checks++; if (lat !== 2) begin failures++; $display("FAIL write_latency got=%0d want=2", lat); end
        checks++; if (extra !== 0) begin failures++; $display("FAIL write_single_pulse extra=%0d want=0", extra); end
        read_a(1, 8'h10, lat, data, post, extra);
        checks++; if (data !== model_a[8'h10]) begin failures++; $display("FAIL write_then_read got=%h want=%h", data, model_a[8'h10]); end
    endtask

    task automatic test_two_channels();
        int lat, extra;
        logic [1:0] seen;
        logic [7:0] data, post;
        @(negedge clk);
        a_wv = 2'b11; a_wa[0] = 8'h20; a_wa[1] = 8'h20; a_wd[0] = 8'h11; a_wd[1] = 8'h22;
        lat = 0; seen = '0;
        while (lat < 50) begin
            @(negedge clk); lat++;
            seen = a_wr;
            if (seen != 2'b00) break;
        end
        @(negedge clk);
        a_wv = 2'b00;
        repeat (3) @(negedge clk);
        model_a[8'h20] = 8'h22;
        checks++; if (seen !== 2'b11) begin failures++; $display("FAIL dual_write_ready got=%b want=11", seen); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL dual_write_latency got=%0d want=2", lat); end
        read_a(0, 8'h20, lat, data, post, extra);
        checks++; if (data !== model_a[8'h20]) begin failures++; $display("FAIL dual_write_winner got=%h want=%h", data, model_a[8'h20]); end

        // Load port and channel 1 write commit to the same address on the same edge.
        @(negedge clk);
        a_wv[1] = 1'b1; a_wa[1] = 8'h30; a_wd[1] = 8'h99;
        @(negedge clk);
        a_le = 1'b1; a_la = 8'h30; a_ld = 8'h4D;
        @(negedge clk);
        a_le = 1'b0;
        @(negedge clk);
        a_wv[1] = 1'b0;
        repeat (3) @(negedge clk);
        model_a[8'h30] = 8'h4D;
        read_a(0, 8'h30, lat, data, post, extra);
        checks++; if (data !== model_a[8'h30]) begin failures++; $display("FAIL load_over_channel got=%h want=%h", data, model_a[8'h30]); end
    endtask

    task automatic test_rw_priority();
        int n, rlat, wlat, rcount, wcount, lat, extra;
        logic [7:0] rdat, data, post;
        load_a(8'h01, 8'h55);
        @(negedge clk);
        a_rv[0] = 1'b1; a_ra[0] = 8'h01;
        a_wv[0] = 1'b1; a_wa[0] = 8'h01; a_wd[0] = 8'h66;
        n = 0; rlat = 0; wlat = 0; rcount = 0; wcount = 0; rdat = '0;
        while (n < 14) begin
            @(negedge clk); n++;
            if (rlat != 0 && n == rlat + 1) a_rv[0] = 1'b0;
            if (wlat != 0 && n == wlat + 1) a_wv[0] = 1'b0;
            if (a_rr[0]) begin rcount++; rlat = n; rdat = a_rd[0]; end
            if (a_wr[0]) begin wcount++; wlat = n; end
        end
        model_a[8'h01] = 8'h66;
        checks++; if (rlat !== 2) begin failures++; $display("FAIL rw_read_latency got=%0d want=2", rlat); end
        checks++; if (rdat !== 8'h55) begin failures++; $display("FAIL rw_read_old_value got=%h want=55", rdat); end
        checks++; if (wlat !== 5) begin failures++; $display("FAIL rw_write_latency got=%0d want=5", wlat); end
        checks++; if (rcount !== 1 || wcount !== 1) begin failures++; $display("FAIL rw_pulse_counts read=%0d write=%0d want=1/1", rcount, wcount); end
        read_a(0, 8'h01, lat, data, post, extra);
        checks++; if (data !== model_a[8'h01]) begin failures++; $display("FAIL rw_final_value got=%h want=%h", data, model_a[8'h01]); end
    endtask

    task automatic test_random();
        int lat, extra, ch;
        logic [7:0] addr, wdata, data, post;
        for (int i = 0; i < 40; i++) begin
            ch   = int'($urandom_range(0, 1));
            addr = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                wdata = 8'($urandom);
                write_a(ch, addr, wdata, lat, extra);
                model_a[addr] = wdata;
                checks++; if (lat !== 2 || extra !== 0) begin failures++; $display("FAIL rand_write ch=%0d addr=%h lat=%0d extra=%0d want=2/0", ch, addr, lat, extra); end
            end else begin
                read_a(ch, addr, lat, data, post, extra);
                checks++; if (lat !== 2 || extra !== 0) begin failures++; $display("FAIL rand_read_timing ch=%0d addr=%h lat=%0d extra=%0d want=2/0", ch, addr, lat, extra); end
                checks++; if (data !== model_a[addr]) begin failures++; $display("FAIL rand_read_data ch=%0d addr=%h got=%h want=%h", ch, addr, data, model_a[addr]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, readies, nonzero;
        logic [7:0] data;
        load_b(8'h07, 8'h33);
        @(negedge clk);
        b_rv = 1'b1; b_ra = 8'h07;
        repeat (2) @(negedge clk);
        b_reset = 1'b1; b_rv = 1'b0;
        @(negedge clk);
        b_reset = 1'b0;
        readies = 0; nonzero = 0;
        repeat (8) begin
            @(negedge clk);
            if (b_rr !== 1'b0) readies++;
            if (b_rd !== 8'h00) nonzero++;
        end
        checks++; if (readies !== 0) begin failures++; $display("FAIL reset_mid_ready got=%0d pulses want=0", readies); end
        checks++; if (nonzero !== 0) begin failures++; $display("FAIL reset_mid_data got=%0d nonzero cycles want=0", nonzero); end
        read_b(8'h07, lat, data);
        checks++; if (lat !== 4) begin failures++; $display("FAIL b_read_latency got=%0d want=4", lat); end
        checks++; if (data !== 8'h33) begin failures++; $display("FAIL reset_mid_preload got=%h want=33", data); end
    endtask

    task automatic test_read_only();
        int lat, readies;
        logic [7:0] data;
        @(negedge clk);
        b_wv = 1'b1; b_wa = 8'h07; b_wd = 8'hEE;
        readies = 0;
        repeat (20) begin
            @(negedge clk);
            if (b_wr !== 1'b0) readies++;
        end
        b_wv = 1'b0;
        checks++; if (readies !== 0) begin failures++; $display("FAIL ro_write_ready got=%0d pulses want=0", readies); end
        read_b(8'h07, lat, data);
        checks++; if (data !== 8'h33) begin failures++; $display("FAIL ro_storage_unchanged got=%h want=33", data); end
        load_b(8'h08, 8'h5A);
        read_b(8'h08, lat, data);
        checks++; if (data !== 8'h5A) begin failures++; $display("FAIL ro_load_port got=%h want=5a", data); end
    endtask

    initial begin
        a_reset = 1'b1; a_rv = '0; a_ra = '0; a_wv = '0; a_wa = '0; a_wd = '0;
        a_le = 1'b0; a_la = '0; a_ld = '0;
        b_reset = 1'b1; b_rv = 1'b0; b_ra = '0; b_wv = 1'b0; b_wa = '0; b_wd = '0;
        b_le = 1'b0; b_la = '0; b_ld = '0;

        test_reset();
        for (int i = 0; i < 16; i++) load_a(8'(i), 8'($urandom));
        test_read_latency();
        test_write_read();
        test_two_channels();
        test_rw_priority();
        test_random();
        test_reset_mid();
        test_read_only();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
